// File: rtl/byte_sram_ctrl.sv
// -----------------------------------------------------------------------------
// byte_sram_ctrl
//
// Single-outstanding request/response controller for a 128 x 8 registered-read
// byte SRAM. A request is latched in IDLE and turned into one SRAM strobe
// cycle (WR or RD). A read then waits one capture cycle for the SRAM output
// register (CAP) and presents the data in RESP until the consumer accepts it.
//
// Optional feature, macro BYTE_SRAM_CTRL_WR_VERIFY_EN:
//   defined   - every write is read back (VRD/VCAP), compared against the
//               written byte, and always answered with a response beat whose
//               rsp_rdata is the read-back value and rsp_err flags a mismatch;
//               err_cnt counts mismatches, saturating at 255.
//   undefined - VRD/VCAP are never entered, rsp_err/err_cnt are tied to 0 and
//               write responses follow the WR_ACK parameter.
//
// Parameters:
//   WR_ACK        1: each write returns one response beat (rsp_rdata = 0)
//                 0: writes complete silently (ignored with verify compiled in)
//
// Ports:
//   sram_clk       in   clock, all state changes on the rising edge
//   sram_ares      in   asynchronous active-high reset (shared with the SRAM)
//   req_valid      in   request offered
//   req_ready      out  controller idle and able to take a request
//   req_write      in   1 = write, 0 = read
//   req_addr[6:0]  in   byte index
//   req_wdata[7:0] in   write data
//   rsp_valid      out  response beat present
//   rsp_ready      in   consumer takes the response beat
//   rsp_rdata[7:0] out  read data / verified read-back / 0
//   rsp_err        out  verify mismatch on this beat
//   err_cnt[7:0]   out  saturating verify mismatch count
//   wr_enable      out  SRAM write strobe
//   rd_enable      out  SRAM read strobe
//   ram_index[6:0] out  SRAM address (last latched request address)
//   sram_data_in   out  SRAM write data (last latched request data)
//   sram_data_out  in   SRAM registered read data, valid the cycle after
//                       rd_enable
// -----------------------------------------------------------------------------
module byte_sram_ctrl #(
  parameter bit WR_ACK = 1'b1
) (
  input  logic       sram_clk,
  input  logic       sram_ares,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] err_cnt,
  output logic       wr_enable,
  output logic       rd_enable,
  output logic [6:0] ram_index,
  output logic [7:0] sram_data_in,
  input  logic [7:0] sram_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    VRD,
    VCAP,
    RESP
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_accept;
  logic [6:0] r_index;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge sram_clk or posedge sram_ares) begin
    if (sram_ares) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs. The strobes depend on r_state only,
  // so there is no combinational path from req_* to the SRAM.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a branch that
  // forgets an assignment then keeps the default instead of inferring a latch.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    wr_enable   = 1'b0;
    rd_enable   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = req_write ? WR : RD;
        end
      end
      WR: begin
        wr_enable = 1'b1;
`ifdef BYTE_SRAM_CTRL_WR_VERIFY_EN
        w_state_nxt = VRD;
`else
        w_state_nxt = WR_ACK ? RESP : IDLE;
`endif
      end
      RD: begin
        rd_enable   = 1'b1;
        w_state_nxt = CAP;
      end
      CAP: begin
        w_state_nxt = RESP;
      end
      VRD: begin
        rd_enable   = 1'b1;
        w_state_nxt = VCAP;
      end
      VCAP: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_accept = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Request latch and read-data capture. rsp_rdata is cleared when a request
  // is taken so an unverified write answers with 0; CAP/VCAP overwrite it with
  // the SRAM output register on their closing edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sram_clk or posedge sram_ares) begin
    if (sram_ares) begin
      r_index <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_index <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= '0;
      end else if ((r_state == CAP) || (r_state == VCAP)) begin
        r_rdata <= sram_data_out;
      end
    end
  end

  assign ram_index    = r_index;
  assign sram_data_in = r_wdata;
  assign rsp_rdata    = r_rdata;

  // ---------------------------------------------------------------------------
  // Write verify: compare the read-back byte with the latched write data.
  // ---------------------------------------------------------------------------
`ifdef BYTE_SRAM_CTRL_WR_VERIFY_EN
  logic       r_err;
  logic [7:0] r_err_cnt;
  logic       w_mismatch;

  assign w_mismatch = (sram_data_out != r_wdata);

  always_ff @(posedge sram_clk or posedge sram_ares) begin
    if (sram_ares) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (r_state == VCAP) begin
        r_err <= w_mismatch;
        if (w_mismatch && (r_err_cnt != 8'hFF)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  assign rsp_err = r_err;
  assign err_cnt = r_err_cnt;
`else
  assign rsp_err = 1'b0;
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_byte_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_sram_ctrl
//
// Two controllers share one clock and reset: instance 0 with WR_ACK=1 and
// instance 1 with WR_ACK=0, each attached to its own behavioural byte SRAM
// (registered read, output forced to 0 when not reading, cleared by reset).
// Instance 0's SRAM can corrupt bit 0 of stored data on demand.
//
// The reference model is a plain byte array per instance plus a mismatch
// counter. Latency is counted in clock edges with the accepting edge as edge 1
// (read 3, acknowledged write 2, verified write 4, silent write: none).
// Inputs change on the falling edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_byte_sram_ctrl;

`ifdef BYTE_SRAM_CTRL_WR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam logic [35:0] RESET_VEC = {1'b1, 35'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_write [2];
  logic [6:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err   [2];
  logic [7:0] err_cnt   [2];
  logic       wr_en     [2];
  logic       rd_en     [2];
  logic [6:0] idx       [2];
  logic [7:0] din       [2];
  logic [7:0] dout      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    byte_sram_ctrl #(
      .WR_ACK((g == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .sram_clk     (clk),
      .sram_ares    (rst),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_write    (req_write[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g]),
      .err_cnt      (err_cnt[g]),
      .wr_enable    (wr_en[g]),
      .rd_enable    (rd_en[g]),
      .ram_index    (idx[g]),
      .sram_data_in (din[g]),
      .sram_data_out(dout[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Behavioural SRAMs
  // ---------------------------------------------------------------------------
  logic [7:0] mem [2][128];
  logic corrupt_one = 1'b0;
  logic corrupt_all = 1'b0;

  // Value the SRAM actually stores for a write (fault injection on instance 0).
  function automatic logic [7:0] stored_value(input int k, input logic [6:0] a,
                                              input logic [7:0] d);
    if (k == 0 && (corrupt_all || (corrupt_one && a == 7'h10 && d == 8'h3C)))
      return d ^ 8'h01;
    return d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 128; i++) mem[k][i] <= 8'h00;
        dout[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k]) mem[k][idx[k]] <= stored_value(k, idx[k], din[k]);
        dout[k] <= rd_en[k] ? mem[k][idx[k]] : 8'h00;
      end
    end
  end

  // Strobe monitor.
  int rd_cnt [2] = '{0, 0};
  int wr_cnt [2] = '{0, 0};
  bit both_seen = 1'b0;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k] === 1'b1) rd_cnt[k] <= rd_cnt[k] + 1;
      if (wr_en[k] === 1'b1) wr_cnt[k] <= wr_cnt[k] + 1;
      if (rd_en[k] === 1'b1 && wr_en[k] === 1'b1) both_seen <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] ref_mem  [2][128];
  int         ref_errs [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 128; i++) ref_mem[k][i] = 8'h00;
      ref_errs[k] = 0;
    end
  endfunction

  function automatic logic [7:0] model_err_cnt(input int k);
    return (ref_errs[k] > 255) ? 8'hFF : 8'(ref_errs[k]);
  endfunction

  // Expected {latency, rsp_rdata, rsp_err} of one transaction; latency 0
  // means no response beat.
  function automatic logic [16:0] model_txn(input int k, input bit wr,
                                            input logic [6:0] a,
                                            input logic [7:0] d);
    logic [7:0] s;
    if (!wr) return {8'd3, ref_mem[k][a], 1'b0};
    s = stored_value(k, a, d);
    ref_mem[k][a] = s;
    if (VERIFY) begin
      if (s != d) ref_errs[k]++;
      return {8'd4, s, (s != d)};
    end
    return (k == 0) ? {8'd2, 8'h00, 1'b0} : 17'd0;
  endfunction

  function automatic logic [35:0] outs(input int k);
    return {req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_err[k], err_cnt[k],
            wr_en[k], rd_en[k], idx[k], din[k]};
  endfunction

  int n_cmp  = 0;
  int n_fail = 0;

  // Drive one request and collect {latency, rsp_rdata, rsp_err} of its
  // response (all zero when no beat appears within 10 edges).
  task automatic txn(input int k, input bit wr, input logic [6:0] a,
                     input logic [7:0] d, output logic [16:0] res);
    int waited;
    int lat;
    res = '0;
    @(negedge clk);
    waited = 0;
    while (req_ready[k] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom);
    req_addr[k]  = 7'($urandom);
    req_wdata[k] = 8'($urandom);
    lat = 1;
    while (rsp_valid[k] !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (rsp_valid[k] === 1'b1) begin
      res = {8'(lat), rsp_rdata[k], rsp_err[k]};
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (outs(k) !== RESET_VEC) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %h expected %h", k, outs(k), RESET_VEC);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_read_top();
    logic [16:0] got, exp;
    int r0, w0;
    r0 = rd_cnt[0];
    w0 = wr_cnt[0];
    exp = model_txn(0, 1'b0, 7'h7F, 8'h00);
    txn(0, 1'b0, 7'h7F, 8'h00, got);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL read_7f: got %h expected %h", got, exp);
    end
    #1;
    n_cmp++;
    if ((rd_cnt[0] - r0) !== 1 || (wr_cnt[0] - w0) !== 0) begin
      n_fail++;
      $display("FAIL read_7f_strobes: got rd=%0d wr=%0d expected rd=1 wr=0",
               rd_cnt[0] - r0, wr_cnt[0] - w0);
    end
  endtask

  task automatic test_write_read();
    logic [16:0] got, exp;
    exp = model_txn(0, 1'b1, 7'h05, 8'hA5);
    txn(0, 1'b1, 7'h05, 8'hA5, got);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL write_05: got %h expected %h", got, exp);
    end
    exp = model_txn(0, 1'b0, 7'h05, 8'h00);
    txn(0, 1'b0, 7'h05, 8'h00, got);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL read_05: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp;
    int lat;
    int beats;
    exp = ref_mem[0][7'h05];
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 7'h05;
    @(negedge clk);
    req_valid[0] = 1'b0;
    lat = 1;
    while (rsp_valid[0] !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d expected 3", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid[0], rsp_rdata[0], req_ready[0]} !== {1'b1, exp, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%h ready=%b expected 1 %h 0",
                 i, rsp_valid[0], rsp_rdata[0], req_ready[0], exp);
      end
      if (i == 1) begin
        // A competing request offered while the response is held.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 7'h00;
      end
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b ready=%b expected 0 1",
               rsp_valid[0], req_ready[0]);
    end
    req_valid[0] = 1'b0;
    beats = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1) beats++;
    end
    n_cmp++;
    if (beats !== 0) begin
      n_fail++;
      $display("FAIL stall_extra_beats: got %0d expected 0", beats);
    end
  endtask

  task automatic test_mid_reset();
    logic [16:0] got, exp;
    int beats;
    exp = model_txn(0, 1'b1, 7'h20, 8'h77);
    txn(0, 1'b1, 7'h20, 8'h77, got);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL mid_reset_prewrite: got %h expected %h", got, exp);
    end
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 7'h20;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n_cmp++;
    if (rd_en[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_in_rd: got rd_enable=%b expected 1", rd_en[0]);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (outs(0) !== RESET_VEC) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected %h", outs(0), RESET_VEC);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    beats = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1) beats++;
    end
    n_cmp++;
    if (beats !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_dropped: got %0d beats expected 0", beats);
    end
    exp = model_txn(0, 1'b0, 7'h20, 8'h00);
    txn(0, 1'b0, 7'h20, 8'h00, got);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL mid_reset_reread: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_no_ack();
    logic [16:0] got, exp;
    logic [7:0] data [3] = '{8'h11, 8'h22, 8'h00};
    for (int i = 0; i < 3; i++) begin
      exp = model_txn(1, (i < 2), 7'h01, data[i]);
      txn(1, (i < 2), 7'h01, data[i], got);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL no_ack_step%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] got, exp;
    int k;
    bit wr;
    logic [6:0] a;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      k  = int'($urandom_range(1, 0));
      wr = 1'($urandom);
      a  = (i % 8 == 0) ? 7'h7F : 7'($urandom_range(15, 0));
      d  = 8'($urandom);
      exp = model_txn(k, wr, a, d);
      txn(k, wr, a, d, got);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] k=%0d wr=%0d a=%h d=%h: got %h expected %h",
                 i, k, wr, a, d, got, exp);
      end
    end
    for (int j = 0; j < 2; j++) begin
      n_cmp++;
      if (err_cnt[j] !== model_err_cnt(j)) begin
        n_fail++;
        $display("FAIL random_err_cnt[%0d]: got %h expected %h", j, err_cnt[j], model_err_cnt(j));
      end
    end
  endtask

`ifdef BYTE_SRAM_CTRL_WR_VERIFY_EN
  task automatic test_verify();
    logic [16:0] got, exp;
    logic [6:0] a;
    logic [7:0] d;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    corrupt_one = 1'b1;
    exp = model_txn(0, 1'b1, 7'h10, 8'h3C);
    txn(0, 1'b1, 7'h10, 8'h3C, got);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL verify_corrupt: got %h expected %h", got, exp);
    end
    n_cmp++;
    if (err_cnt[0] !== model_err_cnt(0)) begin
      n_fail++;
      $display("FAIL verify_err_cnt1: got %h expected %h", err_cnt[0], model_err_cnt(0));
    end
    corrupt_one = 1'b0;
    corrupt_all = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = 7'($urandom);
      d = 8'($urandom);
      exp = model_txn(0, 1'b1, a, d);
      txn(0, 1'b1, a, d, got);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL verify_forced[%0d]: got %h expected %h", i, got, exp);
      end
    end
    corrupt_all = 1'b0;
    n_cmp++;
    if (err_cnt[0] !== model_err_cnt(0)) begin
      n_fail++;
      $display("FAIL verify_err_cnt_sat: got %h expected %h", err_cnt[0], model_err_cnt(0));
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = 7'h00;
      req_wdata[k] = 8'h00;
      rsp_ready[k] = 1'b1;
    end
    test_reset();
    test_read_top();
    test_write_read();
    test_stall();
    test_mid_reset();
    test_no_ack();
    test_random();
`ifdef BYTE_SRAM_CTRL_WR_VERIFY_EN
    test_verify();
`endif
    n_cmp++;
    if (both_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_exclusive: got both-strobes-seen=%b expected 0", both_seen);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
